// File: rtl/result_uart_tx_pkg.sv
// Shared types and constants for the result UART transmitter.
// Imported by the packet FSM and the byte serialiser.
package result_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } tx_state_e;

    localparam logic UART_START_BIT      = 1'b0;
    localparam logic UART_STOP_BIT       = 1'b1;
    localparam int   UART_BITS_PER_FRAME = 10;

endpackage

// File: rtl/result_uart_tx_byte.sv
// One 8N1 frame: baud counter plus LSB-first shifter.
// A load on the last cycle of a stop bit chains frames with no gap.
module uart_tx_byte
    import result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       txd_o,
    output logic       tick_o,
    output logic [3:0] pos_o,
    output logic       frame_done_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    POS_LAST = 4'(UART_BITS_PER_FRAME - 1);

    logic [CW-1:0] cnt_q;
    logic [3:0]    pos_q;
    logic [7:0]    shift_q;
    logic          active_q;
    logic          txd_q;

    assign tick_o       = active_q && (cnt_q == CNT_MAX);
    assign frame_done_o = tick_o && (pos_q == POS_LAST);
    assign pos_o        = pos_q;
    assign txd_o        = txd_q;

    // pos_q: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            pos_q    <= '0;
            shift_q  <= '0;
            active_q <= 1'b0;
            txd_q    <= UART_STOP_BIT;
        end else if (load_i) begin
            cnt_q    <= '0;
            pos_q    <= '0;
            shift_q  <= byte_i;
            active_q <= 1'b1;
            txd_q    <= UART_START_BIT;
        end else if (active_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                if (pos_q == POS_LAST) begin
                    active_q <= 1'b0;
                    txd_q    <= UART_STOP_BIT;
                end else begin
                    pos_q <= pos_q + 4'd1;
                    if (pos_q == 4'd8) begin
                        txd_q <= UART_STOP_BIT;
                    end else begin
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Packet FSM: header, payload MS byte first, XOR checksum.
// Drives the byte serialiser and the controller handshake.
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          NUM_BYTES    = 4,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_tx,
    input  logic [8*NUM_BYTES-1:0] payload,
    output logic                   uart_txd,
    output logic                   tx_busy,
    output logic                   tx_finish
);

    localparam int FRAMES = NUM_BYTES + 2;
    localparam int IW     = $clog2(FRAMES);
    localparam logic [IW-1:0] IDX_LAST = IW'(FRAMES - 1);

    tx_state_e              state_q;
    logic [8*NUM_BYTES-1:0] payload_q;
    logic [7:0]             chk_q;
    logic [7:0]             chk_d;
    logic [IW-1:0]          byte_idx_q;
    logic [IW-1:0]          sel_d;
    logic [7:0]             byte_d;
    logic                   go_q;
    logic                   busy_q;
    logic                   finish_q;
    logic                   load_d;
    logic                   tick;
    logic                   frame_done;
    logic [3:0]             pos;

    always_comb begin
        chk_d = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            chk_d = chk_d ^ payload[8*i +: 8];
        end
    end

    // First frame loads index 0; later loads fetch the byte after the current one
    always_comb begin
        sel_d  = go_q ? byte_idx_q : byte_idx_q + IW'(1);
        byte_d = HEADER;
        if (sel_d == IDX_LAST) begin
            byte_d = chk_q;
        end
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (sel_d == IW'(i + 1)) begin
                byte_d = payload_q[8*(NUM_BYTES-1-i) +: 8];
            end
        end
    end

    assign load_d = go_q
                 || (state_q == STOP && frame_done
                     && byte_idx_q != IDX_LAST);

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_d),
        .byte_i       (byte_d),
        .txd_o        (uart_txd),
        .tick_o       (tick),
        .pos_o        (pos),
        .frame_done_o (frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            payload_q  <= '0;
            chk_q      <= '0;
            byte_idx_q <= '0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_tx) begin
                        payload_q  <= payload;
                        chk_q      <= chk_d;
                        byte_idx_q <= '0;
                        go_q       <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (go_q) begin
                        busy_q <= 1'b1;
                    end
                    if (tick && pos == 4'd0) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick && pos == 4'd8) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (frame_done) begin
                        if (byte_idx_q == IDX_LAST) begin
                            finish_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            byte_idx_q <= byte_idx_q + IW'(1);
                            state_q    <= START;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_busy   = busy_q;
    assign tx_finish = finish_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench: expected bytes queued at start_tx,
// popped as frames are decoded cycle-by-cycle from the line.
module tb_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [15:0] pay0;
    logic [31:0] pay1;
    logic        txd0, busy0, fin0;
    logic        txd1, busy1, fin1;

    int         vectors = 0;
    int         errs    = 0;
    logic [7:0] expq[$];
    bit         ab;

    always #5 clk = ~clk;

    result_uart_tx #(
        .CLKS_PER_BIT (4),
        .NUM_BYTES    (2),
        .HEADER       (8'hA5)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start_tx  (start0),
        .payload   (pay0),
        .uart_txd  (txd0),
        .tx_busy   (busy0),
        .tx_finish (fin0)
    );

    result_uart_tx #(
        .CLKS_PER_BIT (434),
        .NUM_BYTES    (4),
        .HEADER       (8'hA5)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start_tx  (start1),
        .payload   (pay1),
        .uart_txd  (txd1),
        .tx_busy   (busy1),
        .tx_finish (fin1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic txd_of(input int sel);
        return (sel == 0) ? txd0 : txd1;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic fin_of(input int sel);
        return (sel == 0) ? fin0 : fin1;
    endfunction

    task automatic send(input int sel, input logic [31:0] p, input int nb);
        logic [7:0] chk;
        chk = '0;
        expq.push_back(8'hA5);
        for (int i = nb - 1; i >= 0; i--) begin
            expq.push_back(p[8*i +: 8]);
            chk = chk ^ p[8*i +: 8];
        end
        expq.push_back(chk);
        if (sel == 0) begin
            pay0   = p[15:0];
            start0 = 1'b1;
        end else begin
            pay1   = p;
            start1 = 1'b1;
        end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic idle_watch(input int sel, input int n);
        int bad_txd = 0;
        int bad_busy = 0;
        int fins = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (txd_of(sel) !== 1'b1) bad_txd++;
            if (busy_of(sel) !== 1'b0) bad_busy++;
            if (fin_of(sel) !== 1'b0) fins++;
        end
        check_eq("idle_txd", bad_txd, 0);
        check_eq("idle_busy", bad_busy, 0);
        check_eq("idle_fin", fins, 0);
    endtask

    // kind 1: second start_tx at cycle evt_at; kind 2: rst at cycle evt_at
    task automatic rx_packet(input int sel, input int cpb, input int nfr,
                             input int evt_at, input int kind,
                             output bit aborted);
        int         c = 0;
        int         fin_seen = 0;
        int         busy_bad = 0;
        logic [7:0] b;
        logic [7:0] exp;
        logic       first, v, st_bit, sp_bit;
        bit         stable;
        aborted = 1'b0;
        for (int f = 0; f < nfr; f++) begin
            stable = 1'b1;
            b      = '0;
            st_bit = 1'b1;
            sp_bit = 1'b0;
            for (int bi = 0; bi < 10; bi++) begin
                for (int k = 0; k < cpb; k++) begin
                    tick();
                    c++;
                    if (kind != 0 && c == evt_at - 1) begin
                        if (kind == 1) begin
                            pay0   = 16'hFFFF;
                            pay1   = 32'hFFFF_FFFF;
                            start0 = (sel == 0);
                            start1 = (sel == 1);
                        end else begin
                            rst = 1'b1;
                        end
                    end
                    if (kind != 0 && c == evt_at) begin
                        start0 = 1'b0;
                        start1 = 1'b0;
                        if (kind == 2) begin
                            rst = 1'b0;
                            check_eq("rst_txd", txd_of(sel), 1);
                            check_eq("rst_busy", busy_of(sel), 0);
                            check_eq("rst_fin", fin_of(sel), 0);
                            expq.delete();
                            aborted = 1'b1;
                            return;
                        end
                    end
                    v = txd_of(sel);
                    if (k == 0) first = v;
                    else if (v !== first) stable = 1'b0;
                    if (fin_of(sel) !== 1'b0) fin_seen++;
                    if (busy_of(sel) !== 1'b1) busy_bad++;
                end
                if (bi == 0) st_bit = first;
                else if (bi == 9) sp_bit = first;
                else b[bi-1] = first;
            end
            exp = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
            check_eq("byte", b, exp);
            check_eq("start_bit", st_bit, 0);
            check_eq("stop_bit", sp_bit, 1);
            check_eq("bit_stable", stable, 1);
        end
        check_eq("early_fin", fin_seen, 0);
        check_eq("busy_hold", busy_bad, 0);
        check_eq("q_drain", expq.size(), 0);
        tick();
        check_eq("fin_pulse", fin_of(sel), 1);
        check_eq("fin_busy", busy_of(sel), 1);
        check_eq("fin_txd", txd_of(sel), 1);
        tick();
        check_eq("fin_drop", fin_of(sel), 0);
        check_eq("busy_drop", busy_of(sel), 0);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        pay0   = '0;
        pay1   = '0;
        repeat (3) tick();
        check_eq("rst_txd0", txd0, 1);
        check_eq("rst_busy0", busy0, 0);
        check_eq("rst_fin0", fin0, 0);
        check_eq("rst_txd1", txd1, 1);
        rst = 1'b0;
        idle_watch(0, 50);

        send(0, 32'h1234, 2);
        rx_packet(0, 4, 4, 0, 0, ab);
        idle_watch(0, 5);

        send(0, 32'h1234, 2);
        rx_packet(0, 4, 4, 40, 1, ab);
        idle_watch(0, 60);

        send(0, 32'h5A3C, 2);
        rx_packet(0, 4, 4, 0, 0, ab);
        send(0, 32'h00FF, 2);
        rx_packet(0, 4, 4, 0, 0, ab);
        idle_watch(0, 5);

        send(0, 32'h1234, 2);
        rx_packet(0, 4, 4, 70, 2, ab);
        idle_watch(0, 200);
        send(0, 32'hC0DE, 2);
        rx_packet(0, 4, 4, 0, 0, ab);
        idle_watch(0, 5);

        send(1, 32'hDEADBEEF, 4);
        rx_packet(1, 434, 6, 0, 0, ab);
        idle_watch(1, 20);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
